// File: rtl/sram_resp_pkg.sv
// Shared definitions for the CPU data-port SRAM responder: FSM encoding,
// inactive strobe levels and the legal wait-state range.
package sram_resp_pkg;

   // Responder FSM states; the FSM register uses the plain localparam codes below
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } resp_state_e;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Active-low SRAM control strobes, grouped so they register as one bank
   typedef struct packed {
      logic       ce_n;
      logic       oe_n;
      logic       we_n;
      logic [3:0] be_n;
   } sram_strobe_t;

   localparam sram_strobe_t STROBE_INACTIVE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, be_n: 4'hF};

   localparam int WAIT_MIN = 2;
   localparam int WAIT_MAX = 15;

   // Out-of-range wait-state settings are pulled into the range the 4-bit counter supports
   function automatic int clamp_wait(input int w);
      if (w < WAIT_MIN) return WAIT_MIN;
      if (w > WAIT_MAX) return WAIT_MAX;
      return w;
   endfunction

endpackage

// File: rtl/sram_data_responder_pad_regs.sv
// Output register bank for the SRAM pins: address, write data, data-bus
// output enable and the active-low strobes. Resets to the inactive levels.
module sram_pad_regs
   import sram_resp_pkg::*;
#(
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_next,
   input  logic [31:0]       dq_next,
   input  logic              dq_oe_next,
   input  sram_strobe_t      strobe_next,
   output logic [ADDR_W-1:0] addr_reg,
   output logic [31:0]       dq_reg,
   output logic              dq_oe_reg,
   output sram_strobe_t      strobe_reg
);

   // Register every pin-facing signal so the SRAM never sees a combinational glitch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg   <= '0;
         dq_reg     <= '0;
         dq_oe_reg  <= 1'b0;
         strobe_reg <= STROBE_INACTIVE;
      end else begin
         addr_reg   <= addr_next;
         dq_reg     <= dq_next;
         dq_oe_reg  <= dq_oe_next;
         strobe_reg <= strobe_next;
      end
   end

endmodule

// File: rtl/sram_data_responder.sv
// CPU data-port responder for asynchronous 32-bit SRAM with programmable
// wait states. Optional feature macro: SRAM_POSTED_WRITE_EN (writes are
// accepted without stalling and drain in the background).
module sram_data_responder
   import sram_resp_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        ram_ce_i,
   input  logic              ram_we_i,
   input  logic [31:0]       ram_addr_i,
   input  logic [3:0]        ram_sel_i,
   input  logic [31:0]       ram_wdata_i,
   output logic [31:0]       ram_data_o,
   output logic              ram_stall_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   input  logic [31:0]       sram_dq_i,
   output logic [31:0]       sram_dq_o,
   output logic              sram_dq_oe_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [3:0]        sram_be_n_o
);

`ifdef SRAM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   localparam int         WAIT_EFF = clamp_wait(WAIT_CYCLES);
   localparam logic [3:0] CNT_LAST = 4'(WAIT_EFF - 1);

   logic [1:0]        state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              we_reg, we_next;
   logic [31:0]       rdata_reg, rdata_next;

   logic [ADDR_W-1:0] addr_next;
   logic [31:0]       dq_next;
   logic              dq_oe_next;
   sram_strobe_t      strobe_next;
   logic [ADDR_W-1:0] pad_addr;
   logic [31:0]       pad_dq;
   logic              pad_dq_oe;
   sram_strobe_t      pad_strobe;

   logic              req;
   logic              unused_addr_bits;

   assign req              = |ram_ce_i;
   assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

   // Next-state and next-pad values; pads are driven from the same decision as the FSM
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      we_next     = we_reg;
      rdata_next  = rdata_reg;
      addr_next   = pad_addr;
      dq_next     = pad_dq;
      dq_oe_next  = 1'b0;
      strobe_next = STROBE_INACTIVE;
      unique case (state_reg)
         ST_IDLE: begin
            if (req) begin
               state_next       = ST_ACCESS;
               cnt_next         = 4'd0;
               we_next          = ram_we_i;
               addr_next        = ram_addr_i[ADDR_W+1:2];
               dq_next          = ram_wdata_i;
               strobe_next.ce_n = 1'b0;
               if (ram_we_i) begin
                  // First cycle is never the final one, so the write pulse starts here
                  strobe_next.we_n = 1'b0;
                  strobe_next.be_n = ~ram_sel_i;
                  dq_oe_next       = 1'b1;
               end else begin
                  strobe_next.oe_n = 1'b0;
                  strobe_next.be_n = 4'h0;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_reg == CNT_LAST) begin
               if (!we_reg) rdata_next = sram_dq_i;
               state_next = (POSTED && we_reg) ? ST_IDLE : ST_DONE;
            end else begin
               cnt_next    = cnt_reg + 4'd1;
               strobe_next = pad_strobe;
               dq_oe_next  = pad_dq_oe;
               // Release we_n one cycle early so data is held past the write edge
               if (we_reg && (cnt_next == CNT_LAST)) strobe_next.we_n = 1'b1;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM, wait counter, latched direction and read-data holding register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         we_reg    <= 1'b0;
         rdata_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         we_reg    <= we_next;
         rdata_reg <= rdata_next;
      end
   end

   sram_pad_regs #(
      .ADDR_W(ADDR_W)
   ) u_pad_regs (
      .clk        (clk),
      .rst        (rst),
      .addr_next  (addr_next),
      .dq_next    (dq_next),
      .dq_oe_next (dq_oe_next),
      .strobe_next(strobe_next),
      .addr_reg   (pad_addr),
      .dq_reg     (pad_dq),
      .dq_oe_reg  (pad_dq_oe),
      .strobe_reg (pad_strobe)
   );

   // Stall is the only output with a combinational path from the request bus
   assign ram_stall_o  = rst & ((state_reg == ST_IDLE) ? (req & ~(POSTED & ram_we_i))
                                                       : (state_reg == ST_ACCESS));
   assign ram_data_o   = rdata_reg;
   assign sram_addr_o  = pad_addr;
   assign sram_dq_o    = pad_dq;
   assign sram_dq_oe_o = pad_dq_oe;
   assign sram_ce_n_o  = pad_strobe.ce_n;
   assign sram_oe_n_o  = pad_strobe.oe_n;
   assign sram_we_n_o  = pad_strobe.we_n;
   assign sram_be_n_o  = pad_strobe.be_n;

endmodule

// File: tb/tb_sram_data_responder.sv
// Bench for sram_data_responder: directed and random accesses against an
// asynchronous SRAM pin model, checked against a transaction-level memory.
module tb_sram_data_responder;

   localparam int ADDR_W      = 20;
   localparam int WAIT_CYCLES = 2;
`ifdef SRAM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        ram_ce_i;
   logic              ram_we_i;
   logic [31:0]       ram_addr_i;
   logic [3:0]        ram_sel_i;
   logic [31:0]       ram_wdata_i;
   logic [31:0]       ram_data_o;
   logic              ram_stall_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic [31:0]       sram_dq_i;
   logic [31:0]       sram_dq_o;
   logic              sram_dq_oe_o;
   logic              sram_ce_n_o;
   logic              sram_oe_n_o;
   logic              sram_we_n_o;
   logic [3:0]        sram_be_n_o;

   int errors = 0;
   int checks = 0;
   int drain_left = 0;
   int txn = 0;
   logic [31:0] last_read = 32'd0;

   always #5 clk = ~clk;

   sram_data_responder #(
      .ADDR_W(ADDR_W),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ram_ce_i    (ram_ce_i),
      .ram_we_i    (ram_we_i),
      .ram_addr_i  (ram_addr_i),
      .ram_sel_i   (ram_sel_i),
      .ram_wdata_i (ram_wdata_i),
      .ram_data_o  (ram_data_o),
      .ram_stall_o (ram_stall_o),
      .sram_addr_o (sram_addr_o),
      .sram_dq_i   (sram_dq_i),
      .sram_dq_o   (sram_dq_o),
      .sram_dq_oe_o(sram_dq_oe_o),
      .sram_ce_n_o (sram_ce_n_o),
      .sram_oe_n_o (sram_oe_n_o),
      .sram_we_n_o (sram_we_n_o),
      .sram_be_n_o (sram_be_n_o)
   );

   // Power-up content of every SRAM word; two words carry the directed-test values
   function automatic logic [31:0] init_pattern(input logic [ADDR_W-1:0] a);
      if (a == 20'd4) return 32'hDEADBEEF;
      if (a == 20'd8) return 32'h11223344;
      return (32'(a) * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction

   // SRAM pin model: asynchronous read, byte-lane write while ce_n and we_n are low
   logic [31:0] sram_mem   [0:(1<<ADDR_W)-1];
   bit          sram_valid [0:(1<<ADDR_W)-1];

   assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o)
                    ? (sram_valid[sram_addr_o] ? sram_mem[sram_addr_o] : init_pattern(sram_addr_o))
                    : 32'hBAD0BAD0;

   always @(posedge clk) begin
      if (!sram_ce_n_o && !sram_we_n_o) begin
         logic [31:0] cur;
         logic [31:0] bus;
         cur = sram_valid[sram_addr_o] ? sram_mem[sram_addr_o] : init_pattern(sram_addr_o);
         bus = sram_dq_oe_o ? sram_dq_o : 32'hFFFFFFFF;
         for (int b = 0; b < 4; b++)
            if (!sram_be_n_o[b]) cur[8*b +: 8] = bus[8*b +: 8];
         sram_mem[sram_addr_o]   <= cur;
         sram_valid[sram_addr_o] <= 1'b1;
      end
   end

   // Reference memory: what each word should hold after the accepted writes
   logic [31:0] ref_mem [int unsigned];

   function automatic logic [31:0] ref_word(input logic [ADDR_W-1:0] a);
      if (ref_mem.exists(32'(a))) return ref_mem[32'(a)];
      return init_pattern(a);
   endfunction

   task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [3:0] sel, input logic [31:0] d);
      logic [31:0] w;
      w = ref_word(a);
      for (int b = 0; b < 4; b++)
         if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[32'(a)] = w;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ce_n"},  32'(sram_ce_n_o), 32'd1);
      check({tag, "_oe_n"},  32'(sram_oe_n_o), 32'd1);
      check({tag, "_we_n"},  32'(sram_we_n_o), 32'd1);
      check({tag, "_be_n"},  32'(sram_be_n_o), 32'hF);
      check({tag, "_dq_oe"}, 32'(sram_dq_oe_o), 32'd0);
      check({tag, "_stall"}, 32'(ram_stall_o), 32'd0);
      check({tag, "_addr"},  32'(sram_addr_o), 32'd0);
      check({tag, "_dq_o"},  sram_dq_o, 32'd0);
      check({tag, "_rdata"}, ram_data_o, 32'd0);
   endtask

   // Pin levels expected in access cycle idx (0-based) of an access
   task automatic check_pads(input logic we, input logic [ADDR_W-1:0] waddr, input logic [3:0] sel,
                             input logic [31:0] wdata, input int idx);
      logic [3:0] be_exp;
      be_exp = we ? ~sel : 4'h0;
      check("sram_addr", 32'(sram_addr_o), 32'(waddr));
      check("ce_n", 32'(sram_ce_n_o), 32'd0);
      check("be_n", 32'(sram_be_n_o), 32'(be_exp));
      if (we) begin
         check("dq_oe_wr", 32'(sram_dq_oe_o), 32'd1);
         check("dq_o", sram_dq_o, wdata);
         check("oe_n_wr", 32'(sram_oe_n_o), 32'd1);
         check("we_n_wr", 32'(sram_we_n_o), (idx == WAIT_CYCLES - 1) ? 32'd1 : 32'd0);
      end else begin
         check("dq_oe_rd", 32'(sram_dq_oe_o), 32'd0);
         check("oe_n_rd", 32'(sram_oe_n_o), 32'd0);
         check("we_n_rd", 32'(sram_we_n_o), 32'd1);
      end
   endtask

   // One CPU access, entered and left just after a rising edge
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata);
      int stalls;
      int exp_stalls;
      bit posted_wr;
      logic [ADDR_W-1:0] waddr;
      logic [31:0] exp_rd;
      posted_wr  = POSTED && we;
      waddr      = addr[ADDR_W+1:2];
      exp_rd     = ref_word(waddr);
      exp_stalls = drain_left + (posted_wr ? 0 : WAIT_CYCLES + 1);
      ram_ce_i    = 4'($urandom_range(1, 15));
      ram_we_i    = we;
      ram_addr_i  = addr;
      ram_sel_i   = sel;
      ram_wdata_i = wdata;
      stalls = 0;
      @(negedge clk);
      if (drain_left == 0 && !posted_wr) check("accept_ce_n_idle", 32'(sram_ce_n_o), 32'd1);
      while (ram_stall_o === 1'b1 && stalls < 64) begin
         if (drain_left == 0 && stalls >= 1) check_pads(we, waddr, sel, wdata, stalls - 1);
         stalls++;
         @(negedge clk);
      end
      check("stall_cycles", 32'(stalls), 32'(exp_stalls));
      if (!posted_wr) begin
         check("done_ce_n", 32'(sram_ce_n_o), 32'd1);
         check("done_dq_oe", 32'(sram_dq_oe_o), 32'd0);
      end
      if (we) begin
         check("wr_keeps_rdata", ram_data_o, last_read);
         ref_write(waddr, sel, wdata);
      end else begin
         check("rd_data", ram_data_o, exp_rd);
         last_read = exp_rd;
      end
      $display("txn %0d we=%0d addr=%08h sel=%h wdata=%08h stalls=%0d rdata=%08h",
               txn, we, addr, sel, wdata, stalls, ram_data_o);
      txn++;
      @(posedge clk);
      #1;
      ram_ce_i   = 4'h0;
      drain_left = posted_wr ? WAIT_CYCLES : 0;
   endtask

   task automatic idle(input int n);
      ram_ce_i = 4'h0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      drain_left = (drain_left > n) ? drain_left - n : 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic        we;
      rst = 1'b0;
      ram_ce_i = 4'h0;
      ram_we_i = 1'b0;
      ram_addr_i = 32'd0;
      ram_sel_i = 4'h0;
      ram_wdata_i = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Word read of the preloaded word 4
      do_access(1'b0, 32'h0000_0010, 4'hF, 32'd0);
      check("read_deadbeef", ram_data_o, 32'hDEADBEEF);

      // Byte-lane write into word 8, then read the merged word back
      do_access(1'b1, 32'h0000_0020, 4'b0100, 32'h00AB0000);
      do_access(1'b0, 32'h0000_0020, 4'hF, 32'd0);
      check("byte_merge", ram_data_o, 32'h11AB3344);

      // Back-to-back write then read of the same word
      idle(2);
      do_access(1'b1, 32'h0000_0044, 4'hF, 32'hCAFEF00D);
      do_access(1'b0, 32'h0000_0044, 4'b0001, 32'd0);
      check("b2b_raw", ram_data_o, 32'hCAFEF00D);

      // High and low address bits alias onto word 0xC0002
      do_access(1'b0, 32'hFFF0_0008, 4'hF, 32'd0);
      check("alias_data", ram_data_o, init_pattern(20'hC0002));

      // Random mix over a small window so reads hit earlier writes
      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         a[ADDR_W+1:2] = 20'(32'h100 + $urandom_range(0, 15));
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         do_access(we, a, 4'($urandom_range(0, 15)), $urandom);
      end

      // Reset in the middle of a write to an otherwise unused word
      idle(2);
      ram_ce_i    = 4'h1;
      ram_we_i    = 1'b1;
      ram_addr_i  = 32'h000F_C000;
      ram_sel_i   = 4'hF;
      ram_wdata_i = 32'h12345678;
      @(posedge clk);
      #1;
      check("midwr_we_n_low", 32'(sram_we_n_o), 32'd0);
      rst = 1'b0;
      #1;
      check_reset_outputs("midwr");
      ram_ce_i = 4'h0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      last_read  = 32'd0;
      drain_left = 0;

      // Normal operation resumes after reset
      do_access(1'b0, 32'h0000_0044, 4'hF, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_data_responder.md
# sram_data_responder

Responder for the CPU data-memory port: accepts word/byte requests issued on the core's ram address/data/write-enable/byte-select/chip-enable lines and services them against external asynchronous 32-bit SRAM with programmable wait states. It sits between the CPU top and the board SRAM pins. It returns read data and a stall signal that holds the pipeline until each access completes.

## Interface
- ADDR_W, 20, SRAM word-address width.
- WAIT_CYCLES, 2, SRAM access cycles per transfer; legal range 2..15.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- ram_ce_i  input  4  request strobe from CPU; request present when any bit is 1
- ram_we_i  input  1  1 = write, 0 = read
- ram_addr_i  input  32  byte address; bits [ADDR_W+1:2] used, others ignored
- ram_sel_i  input  4  byte enables for writes, bit n = byte lane n
- ram_wdata_i  input  32  write data from CPU
- ram_data_o  output  32  read data to CPU
- ram_stall_o  output  1  1 = CPU must hold request stable
- sram_addr_o  output  ADDR_W  SRAM word address
- sram_dq_i  input  32  SRAM data pins, read path
- sram_dq_o  output  32  SRAM data pins, write path
- sram_dq_oe_o  output  1  1 = drive sram_dq_o onto pins
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  output  1 each  active-low SRAM strobes
- sram_be_n_o  output  4  active-low SRAM byte enables

## Operation
- States: IDLE, ACCESS, DONE. Counter cnt, 4 bits.
- IDLE: request present -> latch addr/we/sel/wdata, cnt=0, go ACCESS; ram_stall_o=1 combinationally in that cycle.
- ACCESS: registered strobes: ce_n=0; read: oe_n=0, be_n=0000; write: be_n=~sel, dq_oe=1, we_n=0 for cnt<WAIT_CYCLES-1, we_n=1 in final cycle (data hold). cnt increments; at cnt==WAIT_CYCLES-1 reads capture sram_dq_i into ram_data_o, go DONE. ram_stall_o=1.
- DONE: all strobes inactive, dq_oe=0, ram_stall_o=0; go IDLE unconditionally (request still on bus is not re-accepted).
- ram_data_o holds last read value; writes do not modify it.
- Sub-word reads return the full word; CPU selects lanes.
- Address aliasing: bits above ADDR_W+1 and bits [1:0] ignored.
- Reset (any time, incl. mid-write): state IDLE, cnt 0, ce_n/oe_n/we_n=1, be_n=1111, dq_oe=0, sram_addr_o=0, sram_dq_o=0, ram_data_o=0, ram_stall_o=0.

## Timing
- Request at cycle 0: stall high cycles 0..WAIT_CYCLES, low at cycle WAIT_CYCLES+1 (DONE). Default: 3 stall cycles, data valid cycle 3.
- Back-to-back: next request earliest cycle WAIT_CYCLES+2; throughput one access per WAIT_CYCLES+2 cycles.
- Strobes/address registered; no combinational path from ram_* inputs to sram_* outputs.
- Only ram_stall_o depends combinationally on ram_ce_i.

## Configuration
- SRAM_POSTED_WRITE_EN defined: write accepted in IDLE with ram_stall_o=0 that cycle; ACCESS runs in background, returns directly to IDLE (no DONE). Any request arriving while busy stalls until drain completes, then is handled normally (read-after-write to same address returns new data). Write latency seen by CPU: 0 stall cycles.
- Undefined: writes follow the blocking IDLE/ACCESS/DONE sequence as reads.

## Structure
- Package sram_resp_pkg: state enum (IDLE, ACCESS, DONE), strobe inactive constants, WAIT_CYCLES legal bounds.
- One sub-module, sram_pad_regs: registered bank for sram_addr_o, sram_dq_o, dq_oe and active-low strobes with async reset to inactive.

## Test plan
- Reset: hold rst=0 mid-write -> all strobes 1, be_n=1111, dq_oe=0, stall=0 within same cycle.
- Read 0x0000_0010, SRAM model word 4 = 0xDEADBEEF, WAIT_CYCLES=2 -> stall 1 for 3 cycles, sram_addr_o=4, ram_data_o=0xDEADBEEF at cycle 3.
- Byte write sel=0100, wdata=0x00AB0000 to 0x20 -> be_n=1011, we_n low 1 cycle then high with dq_oe still 1; read back word 8 = 0x11AB3344 from prior 0x11223344.
- Back-to-back write then read same address -> second request accepted cycle 4, returns written data.
- SRAM_POSTED_WRITE_EN: write then immediate read -> write stall 0 cycles, read stalls 2 extra drain cycles plus 3, returns new data.
- Address 0xFFF0_0008 with ADDR_W=20 -> sram_addr_o=0xC0002 (aliasing).
